rom_fetch_arb: RTL

Instruction-fetch controller for the ELVM CPU program ROM, which is a combinational 256×26-bit read port. It owns the ROM address bus and sequences sequential fetch from a program counter into a 2-entry prefetch queue feeding decode with a valid/ready handshake. It supports pc redirects for jumps and flushes the queue on redirect. It also shares the ROM port with a debug/loader read requester.

---
 rtl/rom_fetch_arb_if.sv | 55 +++++
 rtl/rom_fetch_arb.sv | 113 +++++++++++
 2 files changed

// File: rtl/rom_fetch_arb_if.sv
// rtl/rom_fetch_arb_if.sv - ROM port, decode stream and debug-read bundle for rom_fetch_arb
//
// Purpose: groups the bus-style signals of the fetch arbiter.
// Ports (master = fetch arbiter side):
//   rom_addr   out  ROM address, combinational from the arbiter grant
//   rom_data   in   ROM read data, valid in the same cycle as rom_addr
//   inst_valid out  prefetch queue head valid
//   inst_data  out  queue head instruction word
//   inst_pc    out  address of the queue head instruction
//   inst_ready in   decode accepts the head
//   dbg_req    in   debug read request, level, held until dbg_ack
//   dbg_addr   in   debug read address, stable while dbg_req
//   dbg_ack    out  one-cycle pulse, dbg_data valid that cycle
//   dbg_data   out  registered debug read data
interface rom_fetch_arb_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 26
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              inst_valid;
    logic [DATA_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;
    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output rom_addr,
        input  rom_data,
        output inst_valid,
        output inst_data,
        output inst_pc,
        input  inst_ready,
        input  dbg_req,
        input  dbg_addr,
        output dbg_ack,
        output dbg_data
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  inst_valid,
        input  inst_data,
        input  inst_pc,
        output inst_ready,
        output dbg_req,
        output dbg_addr,
        input  dbg_ack,
        input  dbg_data
    );
endinterface

// File: rtl/rom_fetch_arb.sv
// rtl/rom_fetch_arb.sv - instruction fetch controller sharing the program ROM with a debug reader
//
// Purpose: sequential fetch from fetch_pc into a 2-entry prefetch queue, pc redirect
// with queue flush, and alternating arbitration of the ROM port against debug reads.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   run        in   enables sequential fetch
//   pc_load    in   redirect strobe (jump taken)
//   pc_target  in   redirect address
//   fetch_pc   out  next address to fetch
//   bus        rom_fetch_arb_if.master: ROM port, decode stream, debug read
module rom_fetch_arb #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 26
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 pc_load,
    input  logic [ADDR_W-1:0]    pc_target,
    output logic [ADDR_W-1:0]    fetch_pc,
    rom_fetch_arb_if.master      bus
);

    logic [ADDR_W-1:0]            fetch_pc_q, fetch_pc_d;
    logic [1:0][DATA_W-1:0]       q_data_q, q_data_d;
    logic [1:0][ADDR_W-1:0]       q_pc_q, q_pc_d;
    logic [1:0]                   count_q, count_d;
    logic                         dbg_ack_q, dbg_ack_d;
    logic [DATA_W-1:0]            dbg_data_q, dbg_data_d;
    logic                         last_dbg_q, last_dbg_d;   // 1: last grant went to debug

    logic       pop, full_after_pop, fetch_elig, dbg_elig;
    logic       grant_dbg, grant_fetch;
    logic [1:0] level;

    always_comb begin
        pop            = (count_q != 2'd0) && bus.inst_ready;
        // A full queue that pops this cycle still has room for this cycle's fetch.
        full_after_pop = (count_q == 2'd2) && !pop;
        fetch_elig     = run && !pc_load && !full_after_pop;
        // Blocking the ack cycle keeps a still-held dbg_req from being served twice.
        dbg_elig       = bus.dbg_req && !dbg_ack_q;
        grant_dbg      = dbg_elig && (!fetch_elig || !last_dbg_q);
        grant_fetch    = fetch_elig && !grant_dbg;

        bus.rom_addr   = grant_dbg ? bus.dbg_addr : fetch_pc_q;

        q_data_d = q_data_q;
        q_pc_d   = q_pc_q;
        level    = count_q;
        if (pop) begin
            q_data_d[0] = q_data_q[1];
            q_pc_d[0]   = q_pc_q[1];
            level       = count_q - 2'd1;
        end
        if (grant_fetch) begin
            // level is at most 1 here, so bit 0 selects the free slot.
            q_data_d[level[0]] = bus.rom_data;
            q_pc_d[level[0]]   = fetch_pc_q;
            level              = level + 2'd1;
        end
        count_d = pc_load ? 2'd0 : level;

        if (pc_load) begin
            fetch_pc_d = pc_target;
        end else if (grant_fetch) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
        end else begin
            fetch_pc_d = fetch_pc_q;
        end

        dbg_ack_d  = grant_dbg;
        dbg_data_d = grant_dbg ? bus.rom_data : dbg_data_q;

        if (grant_dbg) begin
            last_dbg_d = 1'b1;
        end else if (grant_fetch) begin
            last_dbg_d = 1'b0;
        end else begin
            last_dbg_d = last_dbg_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= '0;
            q_data_q   <= '0;
            q_pc_q     <= '0;
            count_q    <= 2'd0;
            dbg_ack_q  <= 1'b0;
            dbg_data_q <= '0;
            last_dbg_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            q_data_q   <= q_data_d;
            q_pc_q     <= q_pc_d;
            count_q    <= count_d;
            dbg_ack_q  <= dbg_ack_d;
            dbg_data_q <= dbg_data_d;
            last_dbg_q <= last_dbg_d;
        end
    end

    assign fetch_pc       = fetch_pc_q;
    assign bus.inst_valid = (count_q != 2'd0);
    assign bus.inst_data  = q_data_q[0];
    assign bus.inst_pc    = q_pc_q[0];
    assign bus.dbg_ack    = dbg_ack_q;
    assign bus.dbg_data   = dbg_data_q;

endmodule
